// File: rtl/md_pkg.sv
// Shared constants and FSM state type for the cell exit path.
package md_pkg;
  localparam int N_CELL = 27;
  localparam int DATA_W = 97;
  localparam int CNT_W  = 16;
  localparam int PTR_W  = $clog2(N_CELL);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/rr_find_first.sv
// Circular priority encoder: first set bit of mask at or after ptr, wrapping at N.
module rr_find_first #(
  parameter int N     = 27,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [PTR_W-1:0] ptr,
  input  logic [N-1:0]     mask,
  output logic             found,
  output logic [PTR_W-1:0] index
);

  logic [PTR_W:0] pos;

  // Scan offsets from farthest to nearest so the nearest hit is the one kept.
  always_comb begin
    found = |mask;
    index = '0;
    pos   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      pos = {1'b0, ptr} + (PTR_W + 1)'(i);
      if (pos >= (PTR_W + 1)'(N)) pos = pos - (PTR_W + 1)'(N);
      if (mask[pos[PTR_W-1:0]]) index = pos[PTR_W-1:0];
    end
  end

endmodule

// File: rtl/cell_exit_arbiter.sv
// Round-robin collector that packs up to two cell records per beat for the
// pair exit FIFO and brackets each simulation step with a small FSM.
module cell_exit_arbiter #(
  parameter int N_CELL = md_pkg::N_CELL,
  parameter int DATA_W = md_pkg::DATA_W,
  parameter int CNT_W  = md_pkg::CNT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_start,
  input  logic [N_CELL-1:0]        i_req,
  input  logic [DATA_W*N_CELL-1:0] i_data,
  input  logic [N_CELL-1:0]        i_cell_done,
  output logic [N_CELL-1:0]        o_ack,
  output logic                     o_valid,
  output logic [1:0]               o_pair_en,
  output logic [2*DATA_W-1:0]      o_pair_data,
  input  logic                     i_ready,
  output logic                     o_busy,
  output logic                     o_done,
  output logic [CNT_W-1:0]         o_count
);
  import md_pkg::*;

  localparam int IDX_W = $clog2(N_CELL);

  state_t            state;
  logic [IDX_W-1:0]  ptr;
  logic [IDX_W-1:0]  g0;
  logic [IDX_W-1:0]  g1;
  logic [IDX_W-1:0]  g0_next;
  logic              found0;
  logic              found1;
  logic              load;
  logic [N_CELL-1:0] mask1;
  logic [DATA_W-1:0] cell_data [N_CELL];

  function automatic logic [IDX_W-1:0] step_ptr(input logic [IDX_W-1:0] p);
    return (p == IDX_W'(N_CELL - 1)) ? '0 : p + IDX_W'(1);
  endfunction

  always_comb begin
    for (int k = 0; k < N_CELL; k++) cell_data[k] = i_data[DATA_W*k +: DATA_W];
  end

  // Second grant searches just past the first one, with the first masked out.
  assign g0_next = step_ptr(g0);
  assign mask1   = i_req & ~(N_CELL'(1) << g0);

  rr_find_first #(.N(N_CELL), .PTR_W(IDX_W)) u_find0 (
    .ptr   (ptr),
    .mask  (i_req),
    .found (found0),
    .index (g0)
  );

  rr_find_first #(.N(N_CELL), .PTR_W(IDX_W)) u_find1 (
    .ptr   (g0_next),
    .mask  (mask1),
    .found (found1),
    .index (g1)
  );

  assign load   = (state == RUN) && (!o_valid || i_ready);
  assign o_busy = (state != IDLE);
  assign o_done = (state == DONE);

  always_comb begin
    o_ack = '0;
    if (!rst && load) begin
      if (found0) o_ack[g0] = 1'b1;
      if (found1) o_ack[g1] = 1'b1;
    end
  end

  // A stalled beat keeps its registers untouched until the consumer takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      o_valid     <= 1'b0;
      o_pair_en   <= 2'b00;
      o_pair_data <= '0;
      o_count     <= '0;
    end else begin
      if (state == IDLE && i_start)
        o_count <= '0;
      else if (o_valid && i_ready)
        o_count <= o_count + CNT_W'(o_pair_en[0]) + CNT_W'(o_pair_en[1]);

      case (state)
        IDLE: begin
          if (i_start) begin
            state <= RUN;
            ptr   <= '0;
          end
        end
        RUN: begin
          if (load) begin
            if (found1) begin
              o_pair_data <= {cell_data[g1], cell_data[g0]};
              o_pair_en   <= 2'b11;
              o_valid     <= 1'b1;
              ptr         <= step_ptr(g1);
            end else if (found0) begin
              o_pair_data <= {{DATA_W{1'b0}}, cell_data[g0]};
              o_pair_en   <= 2'b01;
              o_valid     <= 1'b1;
              ptr         <= g0_next;
            end else begin
              o_valid <= 1'b0;
            end
          end
          if (&i_cell_done && !(|i_req)) state <= DRAIN;
        end
        DRAIN: begin
          if (!o_valid || i_ready) begin
            o_valid <= 1'b0;
            state   <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cell_exit_arbiter.sv
// Randomised and directed bench for cell_exit_arbiter against a transaction-level model.
module tb_cell_exit_arbiter;
  import md_pkg::*;

  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_DONE = 3;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     i_start;
  logic [N_CELL-1:0]        i_req;
  logic [DATA_W*N_CELL-1:0] i_data;
  logic [N_CELL-1:0]        i_cell_done;
  logic [N_CELL-1:0]        o_ack;
  logic                     o_valid;
  logic [1:0]               o_pair_en;
  logic [2*DATA_W-1:0]      o_pair_data;
  logic                     i_ready;
  logic                     o_busy;
  logic                     o_done;
  logic [CNT_W-1:0]         o_count;

  cell_exit_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .i_start     (i_start),
    .i_req       (i_req),
    .i_data      (i_data),
    .i_cell_done (i_cell_done),
    .o_ack       (o_ack),
    .o_valid     (o_valid),
    .o_pair_en   (o_pair_en),
    .o_pair_data (o_pair_data),
    .i_ready     (i_ready),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_count     (o_count)
  );

  always #5 clk = ~clk;

  int assertCount = 0;
  int failCount   = 0;

  // Stimulus state: what each cell is currently offering.
  logic [N_CELL-1:0] reqV;
  logic [DATA_W-1:0] cellData [N_CELL];
  logic [N_CELL-1:0] doneV;
  logic              readyV;
  logic              startV;
  int                refillPct;
  int                newReqPct;

  // Reference model of the arbiter's observable behaviour.
  int                mState;
  int                mPtr;
  logic              mValid;
  logic [1:0]        mEn;
  logic [2*DATA_W-1:0] mData;
  logic [CNT_W-1:0]  mCount;
  int                g0, g1, nGrant;
  logic [N_CELL-1:0] expAck;

  task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [DATA_W-1:0] randData();
    return {1'($urandom_range(0, 1)), $urandom, $urandom, $urandom};
  endfunction

  task automatic modelReset();
    mState = M_IDLE;
    mPtr   = 0;
    mValid = 1'b0;
    mEn    = 2'b00;
    mData  = '0;
    mCount = '0;
  endtask

  // Walk the ring from the pointer and take the first two pending cells.
  task automatic findGrants();
    nGrant = 0;
    g0 = -1;
    g1 = -1;
    for (int k = 0; k < N_CELL; k++) begin
      int idx;
      idx = (mPtr + k) % N_CELL;
      if (reqV[idx]) begin
        if (nGrant == 0) g0 = idx;
        else if (nGrant == 1) g1 = idx;
        nGrant++;
      end
    end
    expAck = '0;
    if (mState == M_RUN && (!mValid || readyV)) begin
      if (nGrant >= 1) expAck[g0] = 1'b1;
      if (nGrant >= 2) expAck[g1] = 1'b1;
    end
  endtask

  task automatic modelEdge();
    bit accepted;
    accepted = mValid && readyV;
    if (mState == M_IDLE && startV) mCount = '0;
    else if (accepted) mCount = mCount + CNT_W'(mEn[0]) + CNT_W'(mEn[1]);
    case (mState)
      M_IDLE: if (startV) begin mState = M_RUN; mPtr = 0; end
      M_RUN: begin
        if (!mValid || readyV) begin
          if (nGrant >= 2) begin
            mData = {cellData[g1], cellData[g0]}; mEn = 2'b11; mValid = 1'b1; mPtr = (g1 + 1) % N_CELL;
          end else if (nGrant == 1) begin
            mData = {{DATA_W{1'b0}}, cellData[g0]}; mEn = 2'b01; mValid = 1'b1; mPtr = (g0 + 1) % N_CELL;
          end else begin
            mValid = 1'b0;
          end
        end
        if (&doneV && reqV == '0) mState = M_DRAIN;
      end
      M_DRAIN: if (!mValid || readyV) begin mValid = 1'b0; mState = M_DONE; end
      default: mState = M_IDLE;
    endcase
  endtask

  task automatic driveInputs();
    i_req       = reqV;
    i_cell_done = doneV;
    i_ready     = readyV;
    i_start     = startV;
    for (int k = 0; k < N_CELL; k++) i_data[DATA_W*k +: DATA_W] = cellData[k];
  endtask

  // One clock: drive, check the combinational ack, clock, check registers, update cells.
  task automatic applyStimulus();
    driveInputs();
    #2;
    findGrants();
    checkOutput("ack", o_ack, expAck);
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput("valid", o_valid, mValid);
    checkOutput("pair_en", o_pair_en, mEn);
    checkOutput("pair_data", o_pair_data, mData);
    checkOutput("count", o_count, mCount);
    checkOutput("busy", o_busy, mState != M_IDLE);
    checkOutput("done", o_done, mState == M_DONE);
    reqV   = reqV & ~expAck;
    startV = 1'b0;
    for (int k = 0; k < N_CELL; k++) begin
      if (!doneV[k] && !reqV[k]) begin
        if ((expAck[k] && $urandom_range(0, 99) < refillPct) ||
            (!expAck[k] && $urandom_range(0, 99) < newReqPct)) begin
          reqV[k]     = 1'b1;
          cellData[k] = randData();
        end
      end
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [DATA_W-1:0] t1Data;
    int pairs, singles;
    bit seenDone;

    rst = 1'b1;
    reqV = '0; doneV = '0; readyV = 1'b1; startV = 1'b0;
    refillPct = 0; newReqPct = 0;
    for (int k = 0; k < N_CELL; k++) cellData[k] = randData();
    modelReset();
    driveInputs();
    @(posedge clk);
    #1;
    checkOutput("rst_valid", o_valid, 1'b0);
    checkOutput("rst_en", o_pair_en, 2'b00);
    checkOutput("rst_data", o_pair_data, '0);
    checkOutput("rst_count", o_count, '0);
    checkOutput("rst_done", o_done, 1'b0);
    checkOutput("rst_busy", o_busy, 1'b0);
    checkOutput("rst_ack", o_ack, '0);
    rst = 1'b0;

    $display("[TB] single request from cell 5");
    t1Data = 97'h1_0000_0000_0000_0000_0000_00AB;
    cellData[5] = t1Data;
    reqV = N_CELL'(1) << 5;
    applyStimulus();
    startV = 1'b1;
    applyStimulus();
    applyStimulus();
    checkOutput("t1_en", o_pair_en, 2'b01);
    checkOutput("t1_slot0", o_pair_data[DATA_W-1:0], t1Data);
    checkOutput("t1_slot1", o_pair_data[2*DATA_W-1:DATA_W], '0);

    $display("[TB] wrap from cell 26 to cell 0");
    reqV = N_CELL'(1) << 25;
    applyStimulus();
    reqV = (N_CELL'(1) << 26) | N_CELL'(1);
    applyStimulus();
    checkOutput("t2_en", o_pair_en, 2'b11);
    checkOutput("t2_data", o_pair_data, {cellData[0], cellData[26]});
    applyStimulus();

    $display("[TB] every cell holds one record");
    for (int k = 0; k < N_CELL; k++) cellData[k] = randData();
    reqV = '1;
    pairs = 0;
    singles = 0;
    for (int c = 0; c < 20; c++) begin
      applyStimulus();
      if (o_valid && o_pair_en == 2'b11) pairs++;
      else if (o_valid && o_pair_en == 2'b01) singles++;
    end
    checkOutput("t3_pairs", pairs, 13);
    checkOutput("t3_singles", singles, 1);
    checkOutput("t3_count", o_count, 31);

    $display("[TB] backpressure hold");
    reqV = (N_CELL'(1) << 3) | (N_CELL'(1) << 4);
    applyStimulus();
    readyV = 1'b0;
    reqV = (N_CELL'(1) << 7) | (N_CELL'(1) << 8);
    for (int c = 0; c < 5; c++) applyStimulus();
    readyV = 1'b1;
    applyStimulus();
    checkOutput("t4_reload", o_pair_data, {cellData[8], cellData[7]});

    $display("[TB] drain with stalled beat");
    reqV = N_CELL'(1) << 10;
    applyStimulus();
    readyV = 1'b0;
    doneV = '1;
    for (int c = 0; c < 3; c++) applyStimulus();
    checkOutput("t5_busy_drain", o_busy, 1'b1);
    readyV = 1'b1;
    applyStimulus();
    checkOutput("t5_done", o_done, 1'b1);
    applyStimulus();
    checkOutput("t5_idle", o_busy, 1'b0);

    $display("[TB] randomised step");
    doneV = '0;
    refillPct = 50;
    newReqPct = 20;
    startV = 1'b1;
    seenDone = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      readyV = ($urandom_range(0, 3) != 0);
      if (c > 200) doneV[$urandom_range(0, N_CELL - 1)] = 1'b1;
      applyStimulus();
      if (mState == M_DONE) seenDone = 1'b1;
      if (seenDone && mState == M_IDLE) break;
    end
    checkOutput("rand_idle", o_busy, 1'b0);

    $display("[TB] reset in the middle of a step");
    refillPct = 0;
    newReqPct = 0;
    doneV = '0;
    readyV = 1'b0;
    reqV = '0;
    startV = 1'b1;
    applyStimulus();
    reqV = (N_CELL'(1) << 2) | (N_CELL'(1) << 9);
    applyStimulus();
    checkOutput("t6_loaded", o_valid, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("t6_valid", o_valid, 1'b0);
    checkOutput("t6_en", o_pair_en, 2'b00);
    checkOutput("t6_count", o_count, '0);
    checkOutput("t6_ack", o_ack, '0);
    checkOutput("t6_busy", o_busy, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    modelReset();
    readyV = 1'b1;
    reqV = '0;
    startV = 1'b1;
    applyStimulus();
    reqV = (N_CELL'(1) << 1) | (N_CELL'(1) << 20);
    applyStimulus();
    checkOutput("t6_resume", o_pair_data, {cellData[20], cellData[1]});

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
